// File: rtl/mux_scan_capture.sv
// mux_scan_capture: sequencer that turns an external 8:1 mux into a
// parallel-capture path. On start it steps the select through 0..7, holds each
// channel for SETTLE_CYCLES clocks, samples y into the matching bit and presents
// the assembled byte downstream with a valid/ready handshake.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     scan request, sampled only when idle
//   y         mux output
//   s         mux select
//   busy      high while scanning
//   data_out  captured word, bit k = y observed with s==k
//   valid     data_out holds a new, unconsumed word
//   ready     downstream accepts data_out when valid && ready
//
// Build option: define MUX_SCAN_AUTO_EN to restart scanning immediately after
// each handshake instead of returning to idle.
module mux_scan_capture #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned CNT_W         = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       y,
   output logic [2:0] s,
   output logic       busy,
   output logic [7:0] data_out,
   output logic       valid,
   input  logic       ready
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [2:0]       S_LAST   = 3'd7;

   state_t           state_q, state_d;
   logic [2:0]       s_q, s_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic [7:0]       data_q, data_d;
   logic [7:0]       shadow_q, shadow_d;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         s_q      <= 3'd0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         data_q   <= 8'h00;
         shadow_q <= 8'h00;
      end else begin
         state_q  <= state_d;
         s_q      <= s_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         shadow_q <= shadow_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      valid_d  = valid_q;
      data_d   = data_q;
      shadow_d = shadow_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SCAN;
               s_d     = 3'd0;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end

         ST_SCAN: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               cnt_d       = '0;
               shadow_d[s_q] = y;
               if (s_q != S_LAST) begin
                  s_d = s_q + 3'd1;
               end else begin
                  // Last channel goes straight into the output word, bypassing the shadow.
                  state_d = ST_DONE;
                  data_d  = {y, shadow_q[6:0]};
                  valid_d = 1'b1;
                  busy_d  = 1'b0;
                  s_d     = 3'd0;
               end
            end
         end

         ST_DONE: begin
            if (ready) begin
               valid_d = 1'b0;
`ifdef MUX_SCAN_AUTO_EN
               state_d = ST_SCAN;
               s_d     = 3'd0;
               cnt_d   = '0;
               busy_d  = 1'b1;
`else
               state_d = ST_IDLE;
`endif
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign s        = s_q;
   assign busy     = busy_q;
   assign valid    = valid_q;
   assign data_out = data_q;

endmodule

// File: tb/tb_mux_scan_capture.sv
// Testbench for mux_scan_capture: a behavioural 8:1 mux drives y from a byte
// pattern; every accepted start queues the pattern and the cycle its valid
// must appear, and a monitor pops and compares when valid rises.
module tb_mux_scan_capture;

   localparam int unsigned SETTLE = 2;
   localparam int unsigned SCAN_LEN = 8 * SETTLE;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       y;
   logic [2:0] s;
   logic       busy;
   logic [7:0] data_out;
   logic       valid;
   logic       ready;

   logic [7:0]  mux_in;
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   typedef struct {
      logic [7:0]  word;
      int unsigned vcyc;
   } exp_t;
   exp_t exp_q[$];

   mux_scan_capture #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .y(y), .s(s), .busy(busy),
      .data_out(data_out), .valid(valid), .ready(ready)
   );

   // Reference mux: y is the selected bit of the pattern
   assign y = mux_in[s];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   // Monitor: scoreboard pops on valid rise, plus protocol and timing checks
   initial begin : monitor
      logic       pv, pb;
      logic [7:0] pdata;
      logic [2:0] ps;
      int         brun, hold;
      exp_t       e;
      pv = 1'b0; pb = 1'b0; pdata = 8'h00; ps = 3'd0; brun = 0; hold = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pv = 1'b0; pb = 1'b0; brun = 0; hold = 0;
         end else begin
            if (valid && !pv) begin
               if (exp_q.size() == 0) begin
                  chk(1'b0, "unexpected_valid", 32'(data_out), 32'hx);
               end else begin
                  e = exp_q.pop_front();
                  chk(data_out == e.word, "data_out", 32'(data_out), 32'(e.word));
                  chk(cyc == e.vcyc, "valid_latency", cyc, e.vcyc);
               end
            end
            if (valid && pv)
               chk(data_out == pdata, "data_hold", 32'(data_out), 32'(pdata));
            if (valid && busy)
               chk(1'b0, "busy_while_valid", 32'(busy), 32'd0);
            if (busy) begin
               brun++;
               if (!pb) begin
                  chk(s == 3'd0, "scan_first_s", 32'(s), 32'd0);
                  hold = 1;
               end else if (s != ps) begin
                  chk(s == ps + 3'd1, "s_step", 32'(s), 32'(ps + 3'd1));
                  chk(hold == SETTLE, "s_hold", hold, SETTLE);
                  hold = 1;
               end else begin
                  hold++;
               end
            end else if (pb) begin
               chk(brun == SCAN_LEN, "busy_len", brun, SCAN_LEN);
               chk(hold == SETTLE, "s7_hold", hold, SETTLE);
               chk(s == 3'd0, "s_after_scan", 32'(s), 32'd0);
               brun = 0;
            end
            pv = valid; pb = busy; pdata = data_out; ps = s;
         end
      end
   end

   // Wait (bounded) for valid, entered just after the start-sampling edge
   task automatic wait_valid();
      for (int i = 0; i < int'(SCAN_LEN) + 4; i++) begin
         if (valid) break;
         @(posedge clk); #1;
      end
      chk(valid, "valid_timeout", 32'(valid), 32'd1);
   endtask

   task automatic issue_start(input logic [7:0] pat);
      @(posedge clk); #1;
      mux_in = pat;
      start  = 1'b1;
      exp_q.push_back('{word: pat, vcyc: cyc + 1 + SCAN_LEN});
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // One scan with bp cycles of back-pressure, optionally poking start meanwhile
   task automatic scan(input logic [7:0] pat, input int bp, input bit poke);
      issue_start(pat);
      wait_valid();
      for (int i = 0; i < bp; i++) begin
         if (poke) start = 1'($urandom_range(0, 1));
         mux_in = 8'($urandom);
         @(posedge clk); #1;
      end
      start = 1'b0;
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
      chk(valid == 1'b0, "handshake_valid", 32'(valid), 32'd0);
      chk(busy == 1'b0, "idle_busy", 32'(busy), 32'd0);
      chk(data_out == pat, "data_retained", 32'(data_out), 32'(pat));
      @(posedge clk); #1;
      chk(busy == 1'b0, "start_not_queued", 32'(busy), 32'd0);
   endtask

   initial begin : stim
      int guard;
      rst = 1'b1; start = 1'b0; ready = 1'b0; mux_in = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk(s == 3'd0 && busy == 1'b0 && valid == 1'b0 && data_out == 8'h00,
          "reset_state", {21'd0, s, busy, valid, data_out}, 32'd0);
      rst = 1'b0;

`ifdef MUX_SCAN_AUTO_EN
      ready = 1'b1;
      @(posedge clk); #1;
      mux_in = 8'hA5;
      start  = 1'b1;
      for (int k = 0; k < 4; k++)
         exp_q.push_back('{word: 8'hA5, vcyc: cyc + 1 + SCAN_LEN + k * (SCAN_LEN + 1)});
      @(posedge clk); #1;
      start = 1'b0;
      guard = 0;
      while (exp_q.size() != 0 && guard < 5 * int'(SCAN_LEN + 1)) begin
         @(posedge clk); guard++;
      end
      chk(exp_q.size() == 0, "auto_words", exp_q.size(), 0);
`else
      // Directed patterns, back-pressure with ignored start pokes, random patterns
      scan(8'h21, 0, 1'b0);
      scan(8'h80, 5, 1'b1);
      scan(8'h00, 1, 1'b0);
      scan(8'hFF, 3, 1'b1);
      for (int n = 0; n < 6; n++)
         scan(8'($urandom), int'($urandom_range(0, 5)), 1'b1);

      // start and ready together in DONE: one handshake, start dropped
      issue_start(8'h5C);
      wait_valid();
      start = 1'b1; ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; ready = 1'b0;
      chk(valid == 1'b0, "sim_valid", 32'(valid), 32'd0);
      chk(busy == 1'b0, "sim_busy", 32'(busy), 32'd0);
      scan(8'h3A, 0, 1'b0);

      // Asynchronous reset mid-scan at s==3
      issue_start(8'hE7);
      guard = 0;
      while (s != 3'd3 && guard < int'(SCAN_LEN)) begin
         @(posedge clk); #1; guard++;
      end
      chk(s == 3'd3, "reach_s3", 32'(s), 32'd3);
      #1 rst = 1'b1;
      #1;
      chk(s == 3'd0 && busy == 1'b0 && valid == 1'b0 && data_out == 8'h00,
          "async_reset", {21'd0, s, busy, valid, data_out}, 32'd0);
      exp_q.delete();
      #8 rst = 1'b0;
      @(posedge clk); #1;
      chk(busy == 1'b0 && valid == 1'b0, "idle_after_reset", {30'd0, busy, valid}, 32'd0);
      scan(8'h96, 2, 1'b0);
`endif
      repeat (2) @(posedge clk);
      chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mux_scan_capture.md
Name: mux_scan_capture

Overview:
- Scan controller that pairs with multiplexer8to1. It drives the mux select `s` and consumes the mux output `y`.
- On a start request it steps `s` through 0..7 and waits a programmable settle time per channel. It then samples `y` into bit `s` of an 8-bit word.
- The assembled byte is presented downstream with a valid/ready handshake.
- The block is the sequencing stage that turns the 8:1 mux into a parallel-capture path.

Parameters:
- SETTLE_CYCLES, 2, clocks `s` is held stable per channel before `y` is sampled; legal range 1..15.
- CNT_W, 4, width of the settle counter; must hold SETTLE_CYCLES-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  scan request; sampled only in IDLE
- y  input  1  mux output from multiplexer8to1
- s  output  3  mux select to multiplexer8to1
- busy  output  1  high while scanning (SCAN state)
- data_out  output  8  captured word; bit k = value of y when s==k
- valid  output  1  data_out holds a new, unconsumed word
- ready  input  1  downstream accepts data_out when valid&&ready

Behaviour:
- Reset, asynchronous on rst high, wins over everything:
  - state=IDLE, s=0, cnt=0, busy=0, valid=0, data_out=8'h00, shadow=8'h00.
  - Applies mid-scan or mid-handshake with no partial result kept.
- States are IDLE, SCAN and DONE.
- IDLE:
  - s=0, busy=0, valid=0.
  - On an edge with start=1: go to SCAN with s=0, cnt=0, busy=1.
- SCAN:
  - Every edge increments cnt.
  - On the edge where cnt==SETTLE_CYCLES-1: shadow[s]<=y and cnt<=0.
  - Then, if s!=7, s<=s+1 (no wrap inside a scan).
  - If s==7, go to DONE: data_out<=shadow with bit7 replaced by current y, valid<=1, busy<=0, s<=0.
- DONE:
  - valid=1; data_out is held stable.
  - On an edge with ready=1: valid<=0 and go to IDLE.
- Latency: with start sampled at edge E0, captures occur at edges E(k+1)*SETTLE_CYCLES for k=0..7. valid rises after edge E(8*SETTLE_CYCLES).
  - SETTLE_CYCLES=1 gives valid after E8.
  - SETTLE_CYCLES=2 gives valid after E16.
- start while in SCAN or DONE is ignored; it is not queued.
- start and ready both high in DONE: the handshake completes and the block enters IDLE. start is not accepted that cycle and must be re-asserted.
- ready while valid=0 has no effect.
- data_out changes only on entry to DONE. It retains the last word after the handshake until the next scan completes or reset.
- y is sampled only on capture edges; y changes at other times have no effect.
- s changes only on capture edges, on the DONE entry (to 0), or on reset.

Optional Feature:
- Macro: MUX_SCAN_AUTO_EN.
- Defined:
  - On handshake completion in DONE (ready=1), the block goes directly to SCAN with s=0, cnt=0, busy=1 instead of IDLE.
  - Scanning repeats continuously after the first start.
  - Reset still returns to IDLE, and start is again required.
- Undefined: behaviour is exactly as above, with DONE going to IDLE on ready.

Test Plan:
- Reset: assert rst mid-SCAN at s=3 → s, busy, valid, data_out all 0 immediately (asynchronous), without waiting for clk; state is IDLE after release.
- Single scan, SETTLE_CYCLES=1: the bench model drives y=1 only when s==0 or s==5, then pulses start → valid rises 8 cycles later with data_out=8'h21; s visits 0..7 once each; busy high for exactly 8 cycles.
- Settle timing, SETTLE_CYCLES=2: the bench model outputs y=1 only when s==7 → each s value held exactly 2 clocks; valid after 16 cycles; data_out=8'h80.
- Backpressure: hold ready=0 for 5 cycles after valid, pulse start during that time → valid and data_out stay stable, start is ignored, and the block returns to IDLE only on the ready edge.
- Simultaneous start+ready in DONE → one handshake; the block is in IDLE with busy=0 on the next cycle; a start on the following cycle begins a new scan.
- With MUX_SCAN_AUTO_EN and ready tied to 1: one start → valid pulses once every 8*SETTLE_CYCLES+1 cycles indefinitely, each pulse with the correct word.
